ss_step_sequencer: RTL and testbench

- Autonomous bus master for the LNS matrix processor. It replaces host-side command scripting for one discrete state-space plant step: newx = A·x + B·u, ym = C·x + D·u.
- Drives the processor's din/cs/rd/wr/dataORstatus port from a fixed internal microprogram, generalised to NX states, NU inputs and NY outputs. Supports multi-step runs and a status-poll watchdog.
- Sits between the co-simulation/host wrapper and the matrix processor. The host only loads u and x into processor RAM, then pulses start.

---
 rtl/ss_step_sequencer_pkg.sv | 26 ++
 rtl/ss_step_sequencer_if.sv | 7 +
 rtl/ss_step_sequencer_rom.sv | 98 +++++++++
 rtl/ss_step_sequencer.sv | 114 +++++++++++
 tb/tb_ss_step_sequencer.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/ss_step_sequencer_pkg.sv
// ss_step_sequencer_pkg: processor opcodes, ROM entry kinds, FSM states and RC packing for the plant-step sequencer
package ss_step_sequencer_pkg;
  localparam logic [15:0] COMMAND_RESET            = 16'h0001;
  localparam logic [15:0] COMMAND_SET_RC           = 16'h0002;
  localparam logic [15:0] COMMAND_STORE_CLEAR_A    = 16'h0003;
  localparam logic [15:0] COMMAND_SET_N            = 16'h0004;
  localparam logic [15:0] COMMAND_LOAD_C           = 16'h0005;
  localparam logic [15:0] COMMAND_MULVEC_CR_RECT   = 16'h0006;
  localparam logic [15:0] COMMAND_STORE_CLEAR_VECA = 16'h0007;
  localparam logic [15:0] COMMAND_ADDVEC_A         = 16'h0008;
  localparam logic [15:0] COMMAND_LOAD_A           = 16'h0009;
  localparam int PW = 8;
  typedef enum logic [1:0] {K_CMD, K_DATA, K_WAIT} kind_e;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WRITE, S_GAP, S_POLL_REQ, S_POLL_CHK, S_NEXT, S_DONE, S_ERR
  } state_e;
  typedef struct packed {
    logic [15:0] op;
    logic [1:0]  na;
    logic [15:0] a0;
    logic [15:0] a1;
  } cmd_t;
  function automatic logic [15:0] rc(input int r, input int c);
    return {r[7:0], c[7:0]};
  endfunction
endpackage

// File: rtl/ss_step_sequencer_if.sv
// ss_step_sequencer_if: matrix-processor command/data bus driven by the step sequencer
interface ss_step_sequencer_if #(parameter int DW = 16) ();
  logic [DW-1:0] mp_din, mp_dout;
  logic mp_cs, mp_rd, mp_wr, mp_dataORstatus;
  modport master (output mp_din, mp_cs, mp_rd, mp_wr, mp_dataORstatus, input mp_dout);
  modport slave (input mp_din, mp_cs, mp_rd, mp_wr, mp_dataORstatus, output mp_dout);
endinterface

// File: rtl/ss_step_sequencer_rom.sv
// ss_seq_rom: one plant step as a flat CMD/DATA/WAIT program; SS_XUPDATE_EN appends the x <- newx copy-back
module ss_seq_rom
  import ss_step_sequencer_pkg::*;
#(
  parameter int DW = 16, NX = 6, NU = 6, NY = 2,
  parameter int ADDR_A = 0, ADDR_B = 48, ADDR_C = 84, ADDR_D = 96,
  parameter int ADDR_X = 36, ADDR_U = 42, ADDR_YM = 114, ADDR_NEWX = 108,
  parameter int SCRATCH_ADDR = 250
) (
  input  logic [PW-1:0] pc_i,
  output kind_e         kind_o,
  output logic [DW-1:0] word_o,
  output logic [PW-1:0] len_o
);
`ifdef SS_XUPDATE_EN
  localparam int NC = 34;
`else
  localparam int NC = 31;
`endif
  function automatic cmd_t mk(input logic [15:0] op, input int a);
    return '{op, 2'd1, a[15:0], 16'd0};
  endfunction
  function automatic cmd_t cmd_at(input int i);
    cmd_t c;
    c = '{COMMAND_RESET, 2'd0, 16'd0, 16'd0};
    case (i)
      1:  c = mk(COMMAND_SET_RC, rc(NX, NX));
      2:  c = mk(COMMAND_STORE_CLEAR_A, SCRATCH_ADDR);
      3:  c = mk(COMMAND_SET_N, NX);
      4:  c = mk(COMMAND_LOAD_C, ADDR_A);
      5:  c = mk(COMMAND_MULVEC_CR_RECT, ADDR_X);
      6:  c = mk(COMMAND_SET_RC, rc(1, NX));
      7:  c = mk(COMMAND_STORE_CLEAR_VECA, ADDR_NEWX);
      8:  c = mk(COMMAND_SET_RC, rc(NX, NU));
      9:  c = mk(COMMAND_LOAD_C, ADDR_B);
      10: c = mk(COMMAND_MULVEC_CR_RECT, ADDR_U);
      11: c = mk(COMMAND_SET_RC, rc(1, NX));
      12: c = '{COMMAND_ADDVEC_A, 2'd2, 16'(ADDR_NEWX), 16'd0};
      13: c = mk(COMMAND_STORE_CLEAR_VECA, ADDR_NEWX);
      14: c = mk(COMMAND_SET_N, NY);
      15: c = mk(COMMAND_SET_RC, rc(NY, NX));
      16: c = mk(COMMAND_STORE_CLEAR_A, SCRATCH_ADDR);
      17: c = mk(COMMAND_LOAD_C, ADDR_C);
      18: c = mk(COMMAND_SET_N, NX);
      19: c = mk(COMMAND_MULVEC_CR_RECT, ADDR_X);
      20: c = mk(COMMAND_SET_RC, rc(1, NY));
      21: c = mk(COMMAND_STORE_CLEAR_VECA, ADDR_YM);
      22: c = mk(COMMAND_SET_N, NY);
      23: c = mk(COMMAND_SET_RC, rc(NY, NU));
      24: c = mk(COMMAND_LOAD_C, ADDR_D);
      25: c = mk(COMMAND_SET_N, NU);
      26: c = mk(COMMAND_MULVEC_CR_RECT, ADDR_U);
      27: c = mk(COMMAND_SET_RC, rc(1, NY));
      28: c = mk(COMMAND_SET_N, NY);
      29: c = '{COMMAND_ADDVEC_A, 2'd2, 16'(ADDR_YM), 16'd0};
      30: c = mk(COMMAND_STORE_CLEAR_VECA, ADDR_YM);
`ifdef SS_XUPDATE_EN
      31: c = mk(COMMAND_LOAD_A, ADDR_NEWX);
      32: c = mk(COMMAND_SET_RC, rc(1, NX));
      33: c = mk(COMMAND_STORE_CLEAR_VECA, ADDR_X);
`endif
      default: ;
    endcase
    return c;
  endfunction
  function automatic int prog_len();
    int n;
    cmd_t c;
    n = 0;
    for (int i = 0; i < NC; i++) begin
      c = cmd_at(i);
      n += 1 + 2 * int'(c.na);
    end
    return n;
  endfunction
  localparam int LEN = prog_len();
  assign len_o = PW'(LEN);
  // Each command expands to its opcode followed by a DATA/WAIT pair per argument
  always_comb begin
    int p;
    cmd_t c;
    kind_o = K_CMD;
    word_o = '0;
    p = 0;
    for (int i = 0; i < NC; i++) begin
      c = cmd_at(i);
      if (int'(pc_i) == p) word_o = DW'(c.op);
      for (int k = 0; k < 2; k++) begin
        if (k < int'(c.na) && int'(pc_i) == p + 1 + 2 * k) begin
          kind_o = K_DATA;
          word_o = DW'(k == 0 ? c.a0 : c.a1);
        end
        if (k < int'(c.na) && int'(pc_i) == p + 2 + 2 * k) kind_o = K_WAIT;
      end
      p += 1 + 2 * int'(c.na);
    end
  end
endmodule

// File: rtl/ss_step_sequencer.sv
// ss_step_sequencer: autonomous bus master running n plant steps on the LNS matrix processor
// with a status-poll watchdog; SS_XUPDATE_EN selects the state-updating program variant.
module ss_step_sequencer
  import ss_step_sequencer_pkg::*;
#(
  parameter int DW = 16, NX = 6, NU = 6, NY = 2,
  parameter int ADDR_A = 0, ADDR_B = 48, ADDR_C = 84, ADDR_D = 96,
  parameter int ADDR_X = 36, ADDR_U = 42, ADDR_YM = 114, ADDR_NEWX = 108,
  parameter int SCRATCH_ADDR = 250, TIMEOUT_CYC = 4096
) (
  input  logic        sysclk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] n_steps,
  output logic        busy,
  output logic        done,
  output logic        err_timeout,
  output logic [15:0] step_count,
  ss_step_sequencer_if.master mp
);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  state_e state_q, state_d;
  logic [PW-1:0] pc_q, pc_d, len;
  logic [WW-1:0] wd_q, wd_d;
  logic [15:0] steps_q, steps_d, cnt_q, cnt_d;
  logic err_q, err_d;
  kind_e kind;
  logic [DW-1:0] word;
  ss_seq_rom #(
    .DW(DW), .NX(NX), .NU(NU), .NY(NY), .ADDR_A(ADDR_A), .ADDR_B(ADDR_B), .ADDR_C(ADDR_C),
    .ADDR_D(ADDR_D), .ADDR_X(ADDR_X), .ADDR_U(ADDR_U), .ADDR_YM(ADDR_YM),
    .ADDR_NEWX(ADDR_NEWX), .SCRATCH_ADDR(SCRATCH_ADDR)
  ) u_rom (.pc_i(pc_q), .kind_o(kind), .word_o(word), .len_o(len));
  assign busy = !(state_q inside {S_IDLE, S_DONE, S_ERR});
  assign done = state_q inside {S_DONE, S_ERR};
  assign err_timeout = err_q;
  assign step_count = cnt_q;
  always_ff @(posedge sysclk or negedge reset_n)
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q <= '0;
      wd_q <= '0;
      steps_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      wd_q <= wd_d;
      steps_q <= steps_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  // Strobes decode straight from the state register so reset drops them without a clock
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    wd_d = wd_q;
    steps_d = steps_q;
    cnt_d = cnt_q;
    err_d = err_q;
    mp.mp_din = '0;
    mp.mp_cs = 1'b0;
    mp.mp_rd = 1'b0;
    mp.mp_wr = 1'b0;
    mp.mp_dataORstatus = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_FETCH;
        pc_d = '0;
        cnt_d = '0;
        err_d = 1'b0;
        steps_d = n_steps == 16'd0 ? 16'd1 : n_steps;
      end
      S_FETCH: begin
        state_d = kind == K_WAIT ? S_POLL_REQ : S_WRITE;
        wd_d = '0;
      end
      S_WRITE: begin
        mp.mp_cs = 1'b1;
        mp.mp_wr = 1'b1;
        mp.mp_din = word;
        mp.mp_dataORstatus = kind == K_DATA;
        state_d = S_GAP;
      end
      S_GAP: state_d = S_NEXT;
      S_POLL_REQ: begin
        mp.mp_cs = 1'b1;
        mp.mp_rd = 1'b1;
        state_d = S_POLL_CHK;
      end
      S_POLL_CHK:
        if (mp.mp_dout[0]) state_d = S_NEXT;
        else if (int'(wd_q) + 1 >= TIMEOUT_CYC) begin
          state_d = S_ERR;
          err_d = 1'b1;
        end else begin
          wd_d = wd_q + WW'(1);
          state_d = S_POLL_REQ;
        end
      S_NEXT:
        if (pc_q == len - PW'(1)) begin
          cnt_d = cnt_q + 16'd1;
          pc_d = '0;
          state_d = cnt_d == steps_q ? S_DONE : S_FETCH;
        end else begin
          pc_d = pc_q + PW'(1);
          state_d = S_FETCH;
        end
      S_DONE, S_ERR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_ss_step_sequencer.sv
// tb_ss_step_sequencer: directed trace, multi-step, timeout, mid-run reset and geometry checks for ss_step_sequencer
module tb_ss_step_sequencer;
  import ss_step_sequencer_pkg::*;
  typedef struct packed {logic dat; logic [15:0] w;} wr_t;
  typedef struct {logic [15:0] n; logic [15:0] exp_cnt; bit poke;} run_t;
  logic sysclk = 1'b0, reset_n = 1'b0, start = 1'b0, start2 = 1'b0, rdy = 1'b1;
  logic [15:0] n_steps = 16'd1;
  logic busy, done, err_timeout, busy2, done2, err2;
  logic [15:0] step_count, step_count2;
  wr_t trace [0:4095];
  wr_t trace2 [0:255];
  wr_t exp_tab[$];
  int nw = 0, nr = 0, nd = 0, nw2 = 0, nd2 = 0;
  int total = 0, bad = 0, polls = 0;
  ss_step_sequencer_if #(.DW(16)) bus ();
  ss_step_sequencer_if #(.DW(16)) bus2 ();
  assign bus.mp_dout = {15'd0, rdy};
  assign bus2.mp_dout = 16'd1;
  ss_step_sequencer dut (
    .sysclk(sysclk), .reset_n(reset_n), .start(start), .n_steps(n_steps), .busy(busy),
    .done(done), .err_timeout(err_timeout), .step_count(step_count), .mp(bus)
  );
  ss_step_sequencer #(.NX(4), .NU(2), .NY(3)) dut2 (
    .sysclk(sysclk), .reset_n(reset_n), .start(start2), .n_steps(16'd1), .busy(busy2),
    .done(done2), .err_timeout(err2), .step_count(step_count2), .mp(bus2)
  );
  always #5 sysclk = ~sysclk;
  always @(negedge sysclk) begin
    if (bus.mp_cs && bus.mp_wr) begin
      trace[nw[11:0]] = '{bus.mp_dataORstatus, bus.mp_din};
      nw++;
    end
    if (bus.mp_cs && bus.mp_rd) nr++;
    if (done) nd++;
    if (bus2.mp_cs && bus2.mp_wr) begin
      trace2[nw2[7:0]] = '{bus2.mp_dataORstatus, bus2.mp_din};
      nw2++;
    end
    if (done2) nd2++;
  end
  task automatic tick();
    @(negedge sysclk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic cmd(input logic [15:0] op, input int na, input logic [15:0] a0, input logic [15:0] a1);
    exp_tab.push_back('{1'b0, op});
    if (na > 0) exp_tab.push_back('{1'b1, a0});
    if (na > 1) exp_tab.push_back('{1'b1, a1});
    polls += na;
  endtask
  task automatic run(input logic [15:0] n, input bit poke, input int budget);
    int nd0;
    nd0 = nd;
    n_steps = n;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_steps = 16'd9;
    chk("busy_after_start", busy, 1'b1);
    for (int c = 0; c < budget && nd == nd0; c++) begin
      start = poke && (c == 40 || c == 400);
      tick();
    end
    start = 1'b0;
    chk("done_seen", nd > nd0, 1'b1);
    repeat (3) tick();
    chk("done_pulses", nd - nd0, 1);
    chk("busy_idle", busy, 1'b0);
  endtask
  task automatic check_trace(input int base, input int reps);
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < exp_tab.size(); i++)
        chk($sformatf("trace_s%0d_w%0d", r, i), trace[base + r * exp_tab.size() + i], exp_tab[i]);
  endtask
  run_t runs [4];
  initial begin
    int nw0, nr0;
    cmd(COMMAND_RESET, 0, 0, 0);
    cmd(COMMAND_SET_RC, 1, 16'h0606, 0);
    cmd(COMMAND_STORE_CLEAR_A, 1, 250, 0);
    cmd(COMMAND_SET_N, 1, 6, 0);
    cmd(COMMAND_LOAD_C, 1, 0, 0);
    cmd(COMMAND_MULVEC_CR_RECT, 1, 36, 0);
    cmd(COMMAND_SET_RC, 1, 16'h0106, 0);
    cmd(COMMAND_STORE_CLEAR_VECA, 1, 108, 0);
    cmd(COMMAND_SET_RC, 1, 16'h0606, 0);
    cmd(COMMAND_LOAD_C, 1, 48, 0);
    cmd(COMMAND_MULVEC_CR_RECT, 1, 42, 0);
    cmd(COMMAND_SET_RC, 1, 16'h0106, 0);
    cmd(COMMAND_ADDVEC_A, 2, 108, 0);
    cmd(COMMAND_STORE_CLEAR_VECA, 1, 108, 0);
    cmd(COMMAND_SET_N, 1, 2, 0);
    cmd(COMMAND_SET_RC, 1, 16'h0206, 0);
    cmd(COMMAND_STORE_CLEAR_A, 1, 250, 0);
    cmd(COMMAND_LOAD_C, 1, 84, 0);
    cmd(COMMAND_SET_N, 1, 6, 0);
    cmd(COMMAND_MULVEC_CR_RECT, 1, 36, 0);
    cmd(COMMAND_SET_RC, 1, 16'h0102, 0);
    cmd(COMMAND_STORE_CLEAR_VECA, 1, 114, 0);
    cmd(COMMAND_SET_N, 1, 2, 0);
    cmd(COMMAND_SET_RC, 1, 16'h0206, 0);
    cmd(COMMAND_LOAD_C, 1, 96, 0);
    cmd(COMMAND_SET_N, 1, 6, 0);
    cmd(COMMAND_MULVEC_CR_RECT, 1, 42, 0);
    cmd(COMMAND_SET_RC, 1, 16'h0102, 0);
    cmd(COMMAND_SET_N, 1, 2, 0);
    cmd(COMMAND_ADDVEC_A, 2, 114, 0);
    cmd(COMMAND_STORE_CLEAR_VECA, 1, 114, 0);
`ifdef SS_XUPDATE_EN
    cmd(COMMAND_LOAD_A, 1, 108, 0);
    cmd(COMMAND_SET_RC, 1, 16'h0106, 0);
    cmd(COMMAND_STORE_CLEAR_VECA, 1, 36, 0);
`endif
    runs[0] = '{16'd1, 16'd1, 1'b0};
    runs[1] = '{16'd0, 16'd1, 1'b0};
    runs[2] = '{16'd2, 16'd2, 1'b1};
    runs[3] = '{16'd3, 16'd3, 1'b0};
    start = 1'b1;
    repeat (3) tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err_timeout, 1'b0);
    chk("rst_step_count", step_count, 16'd0);
    chk("rst_strobes", {bus.mp_cs, bus.mp_rd, bus.mp_wr, bus.mp_dataORstatus}, 4'd0);
    chk("rst_din", bus.mp_din, 16'd0);
    start = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("busy_after_release", busy, 1'b0);
    for (int k = 0; k < 4; k++) begin
      nw0 = nw;
      nr0 = nr;
      run(runs[k].n, runs[k].poke, 1000 * int'(runs[k].exp_cnt) + 200);
      chk("step_count", step_count, runs[k].exp_cnt);
      chk("err_clear", err_timeout, 1'b0);
      chk("write_count", nw - nw0, exp_tab.size() * int'(runs[k].exp_cnt));
      chk("poll_count", nr - nr0, polls * int'(runs[k].exp_cnt));
      check_trace(nw0, int'(runs[k].exp_cnt));
    end
    rdy = 1'b0;
    nw0 = nw;
    nr0 = nr;
    run(16'd1, 1'b0, 20000);
    chk("to_err", err_timeout, 1'b1);
    chk("to_polls", nr - nr0, 4096);
    chk("to_writes", nw - nw0, 3);
    chk("to_step_count", step_count, 16'd0);
    rdy = 1'b1;
    n_steps = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_cleared_by_start", err_timeout, 1'b0);
    for (int c = 0; c < 1000 && busy; c++) tick();
    repeat (3) tick();
    chk("err_after_good_run", err_timeout, 1'b0);
    chk("step_after_err", step_count, 16'd1);
    nw0 = nw;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 500 && nw - nw0 < 10; c++) tick();
    chk("tenth_write_seen", {bus.mp_cs, bus.mp_wr}, 2'b11);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_strobes", {bus.mp_cs, bus.mp_rd, bus.mp_wr}, 3'd0);
    chk("rst_mid_busy", busy, 1'b0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    nw0 = nw;
    run(16'd1, 1'b0, 1200);
    chk("restart_first", trace[nw0], {1'b0, COMMAND_RESET});
    check_trace(nw0, 1);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int c = 0; c < 1200 && nd2 == 0; c++) tick();
    chk("g2_done", nd2, 1);
    chk("g2_rc_nxnx", trace2[2], {1'b1, 16'h0404});
    chk("g2_step9_cmd", trace2[15], {1'b0, COMMAND_SET_RC});
    chk("g2_step9_data", trace2[16], {1'b1, 16'h0402});
    chk("g2_step_count", step_count2, 16'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
